// File: rtl/uart_receiver.sv
// 8N1 UART receiver running on an OVERSAMPLE x baud clock: synchronizes rx,
// validates the start bit, majority-votes every bit and checks the stop bit.
`timescale 1ns/1ps

module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rx,
    output logic [7:0] out,
    output logic       done,
    output logic       err,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        RECEIVING = 2'd2,
        STOP      = 2'd3
    } state_t;

    function automatic logic majority3(input logic [2:0] samples);
        return (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
    endfunction

    logic          rx_meta_r;
    logic          rx_sync_r;
    logic          rx_prev_r;
    logic [2:0]    hist_r;
    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    data_r;
    logic [7:0]    out_r;
    logic          done_r;
    logic          err_r;
    logic          busy_r;

    state_t        state_nxt_s;
    logic [CW-1:0] cnt_nxt_s;
    logic [2:0]    bit_idx_nxt_s;
    logic [7:0]    data_nxt_s;
    logic [7:0]    out_nxt_s;
    logic          done_nxt_s;
    logic          err_nxt_s;
    logic          busy_nxt_s;
    logic          vote_s;
    logic          fall_s;

    assign vote_s = majority3(hist_r);
    assign fall_s = rx_prev_r & ~rx_sync_r;

    // Two-stage synchronizer, edge-detect delay and vote history, all idling high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
            hist_r    <= 3'b111;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
            hist_r    <= {hist_r[1:0], rx_sync_r};
        end
    end

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, bit timing and output strobes
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        data_nxt_s    = data_r;
        out_nxt_s     = out_r;
        done_nxt_s    = 1'b0;
        err_nxt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable && fall_s) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = START;
                end else begin
                    cnt_nxt_s   = cnt_r;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (!vote_s) begin
                        bit_idx_nxt_s = 3'd0;
                        state_nxt_s   = RECEIVING;
                    end else begin
                        // Start bit did not hold until its centre: treat as noise
                        state_nxt_s   = IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            RECEIVING: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_nxt_s  = CNT_ZERO;
                    data_nxt_s = {vote_s, data_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s   = STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = IDLE;
                    if (vote_s) begin
                        out_nxt_s  = data_r;
                        done_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s  = 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            data_r    <= 8'h00;
            out_r     <= 8'h00;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            data_r    <= data_nxt_s;
            out_r     <= out_nxt_s;
            done_r    <= done_nxt_s;
            err_r     <= err_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign out  = out_r;
    assign done = done_r;
    assign err  = err_r;
    assign busy = busy_r;

    uart_receiver_checker u_checker (
        .clk  (clk),
        .rst  (rst),
        .done (done_r),
        .err  (err_r),
        .busy (busy_r)
    );

endmodule

// Strobe integrity properties for the receiver outputs.
module uart_receiver_checker (
    input logic clk,
    input logic rst,
    input logic done,
    input logic err,
    input logic busy
);

    a_strobes_exclusive: assert property (@(posedge clk) disable iff (rst) !(done && err));
    a_done_single:       assert property (@(posedge clk) disable iff (rst) done |=> !done);
    a_err_single:        assert property (@(posedge clk) disable iff (rst) err |=> !err);
    a_strobe_idle:       assert property (@(posedge clk) disable iff (rst) (done || err) |-> !busy);

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized bench for uart_receiver: frames are driven bit-by-bit and every
// strobe is scored against a frame-level model (byte, stop bit, enable, latency).
`timescale 1ns/1ps

module tb_uart_receiver;

    localparam int OS      = 16;
    localparam int LATENCY = OS / 2 + 9 * OS + 3;  // detect edge is 3 clk after rx falls

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       rx;
    logic [7:0] out;
    logic       done;
    logic       err;
    logic       busy;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    logic [7:0]  model_out;

    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  data;
        int unsigned at;
    } ev_t;

    ev_t obs_q[$];
    ev_t mon_ev;

    always #5 clk = ~clk;

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .rx     (rx),
        .out    (out),
        .done   (done),
        .err    (err),
        .busy   (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe cycle seen by the monitor
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            mon_ev.kind = {done, err};
            mon_ev.data = out;
            mon_ev.at   = cyc;
            obs_q.push_back(mon_ev);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame; the model expects a strobe only if enable was high at the start bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit spikes,
                              input int drop_en_at, input int rst_at, input int gap);
        logic [9:0]  bits;
        logic        expect_ev;
        logic        v;
        int unsigned c0;
        bit          aborted;
        ev_t         e;
        bits      = {stop, d, 1'b0};
        expect_ev = enable;
        aborted   = 1'b0;
        c0        = cyc;
        for (int b = 0; b < 10 && !aborted; b++) begin
            for (int i = 0; i < OS && !aborted; i++) begin
                v = bits[b];
                if (spikes && b >= 1 && b <= 8 && i == OS / 2) v = ~v;
                rx = v;
                if (b * OS + i == drop_en_at) enable = 1'b0;
                if (b * OS + i == 5 * OS) check_eq("busy_mid", busy, expect_ev);
                if (b * OS + i == rst_at) begin
                    rst = 1'b1;
                    #1;
                    check_eq("rst_out", out, 8'h00);
                    check_eq("rst_done", done, 1'b0);
                    check_eq("rst_err", err, 1'b0);
                    check_eq("rst_busy", busy, 1'b0);
                    model_out = 8'h00;
                    aborted   = 1'b1;
                end else begin
                    tick();
                end
            end
        end
        if (aborted) begin
            tick();
            rst = 1'b0;
        end
        rx     = 1'b1;
        enable = 1'b1;
        for (int g = 0; g < gap; g++) tick();
        if (aborted || !expect_ev) begin
            check_eq("no_event", obs_q.size(), 0);
        end else begin
            check_eq("event_count", obs_q.size(), 1);
            if (obs_q.size() > 0) begin
                e = obs_q.pop_front();
                check_eq("latency", e.at - c0, LATENCY);
                if (stop) begin
                    check_eq("kind_done", {30'd0, e.kind}, 32'd2);
                    check_eq("byte", e.data, d);
                    model_out = d;
                end else begin
                    check_eq("kind_err", {30'd0, e.kind}, 32'd1);
                end
            end
        end
        check_eq("out_hold", out, model_out);
        check_eq("busy_idle", busy, 1'b0);
        obs_q.delete();
    endtask

    task automatic glitch();
        int n;
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        check_eq("glitch_busy_rise", busy, 1'b1);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check_eq("glitch_busy_drop", busy, 1'b0);
        check_eq("glitch_drop_time", (n <= 8) ? 32'd1 : 32'd0, 32'd1);
        repeat (20) tick();
        check_eq("glitch_no_event", obs_q.size(), 0);
        check_eq("glitch_out", out, model_out);
        obs_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       stop;
        bit         spk;
        int         drop;
        int         gap;
        model_out = 8'h00;
        rst       = 1'b1;
        rx        = 1'b1;
        enable    = 1'b1;
        repeat (3) tick();
        check_eq("reset_out", out, 8'h00);
        check_eq("reset_done", done, 1'b0);
        check_eq("reset_err", err, 1'b0);
        check_eq("reset_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (5) tick();

        send_frame(8'hA5, 1'b1, 1'b0, -1, -1, 20);
        send_frame(8'h3C, 1'b0, 1'b0, -1, -1, 2 * OS);
        send_frame(8'h5A, 1'b1, 1'b0, -1, -1, 10);
        glitch();
        send_frame(8'h00, 1'b1, 1'b0, -1, -1, 0);
        send_frame(8'hFF, 1'b1, 1'b0, -1, -1, 10);
        send_frame(8'h00, 1'b1, 1'b1, -1, -1, 10);
        send_frame(8'hE7, 1'b1, 1'b0, -1, -1, 10);
        send_frame(8'h96, 1'b1, 1'b0, -1, 4 * OS + 6, 20);
        enable = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, -1, -1, 10);
        send_frame(8'h81, 1'b1, 1'b0, -1, -1, 10);
        send_frame(8'h6B, 1'b1, 1'b0, 2 * OS + 8, -1, 10);

        for (int k = 0; k < 30; k++) begin
            d      = 8'($urandom);
            stop   = ($urandom_range(0, 3) != 0);
            spk    = ($urandom_range(0, 2) == 0);
            drop   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 150)) : -1;
            gap    = stop ? int'($urandom_range(0, 20)) : int'($urandom_range(16, 40));
            enable = ($urandom_range(0, 5) != 0);
            send_frame(d, stop, spk, drop, -1, gap);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
